// File: rtl/spi_memory_sync_pkg.sv
// Shared constants, FSM encoding and helpers for the SPI-to-memory bridge.
package spi_memory_sync_pkg;

   localparam int   BYTE_WIDTH         = 8;
   localparam logic SPI_MEM_WRITE_FLAG = 1'b1;

   typedef enum logic [1:0] {
      SPI_MEM_STATE_IDLE   = 2'd0,
      SPI_MEM_STATE_HEADER = 2'd1,
      SPI_MEM_STATE_WRITE  = 2'd2,
      SPI_MEM_STATE_READ   = 2'd3
   } spi_mem_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spi_memory_sync_edge.sv
// spi_sync_edge: 2-flop synchronizer for an asynchronous pin plus registered
// single-clock rise/fall pulses.
module spi_sync_edge #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic _reset,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic meta;
   logic sync;
   logic sync_d;

   // Reset to the pin's idle level so releasing reset never fakes an edge.
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         meta   <= RESET_VAL;
         sync   <= RESET_VAL;
         sync_d <= RESET_VAL;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the pre-edge
         // value of its source, which is what builds the shift chain.
         meta   <= din;
         sync   <= meta;
         sync_d <= sync;
         rise   <= sync & ~sync_d;
         fall   <= ~sync & sync_d;
      end
   end

endmodule

// File: rtl/spi_memory_sync.sv
// SPI (mode 0) to single-port memory bridge in the clk domain. Define
// SPI_MEM_READBACK_EN to build the read path (rd strobes, miso shifter).
module spi_memory_sync
   import spi_memory_sync_pkg::*;
#(
   parameter int ADDR_BYTES   = 2,
   parameter int ADDR_WIDTH   = 15,
   parameter int DATA_BYTES   = 1,
   parameter int READ_LATENCY = 1
) (
   input  logic                             clk,
   input  logic                             _reset,
   input  logic                             _select,
   input  logic                             sck,
   input  logic                             mosi,
   output logic                             miso,
   output logic                             miso_en,
   output logic [ADDR_WIDTH-1:0]            addr,
   input  logic [BYTE_WIDTH*DATA_BYTES-1:0] data_in,
   output logic [BYTE_WIDTH*DATA_BYTES-1:0] data_out,
   output logic                             rd,
   output logic                             wr
);

   localparam int HDR_W = BYTE_WIDTH * ADDR_BYTES;
   localparam int DW    = BYTE_WIDTH * DATA_BYTES;
   localparam int SR_W  = max_int(HDR_W, DW) - 1;
   localparam int CNT_W = 6;

   spi_mem_state_t state;
   spi_mem_state_t state_next;

   logic sck_rise;
   logic sck_fall;
   logic sel_rise;
   logic sel_fall;
   logic mosi_meta;
   logic mosi_s;

   logic [CNT_W-1:0]      bit_cnt;
   logic [SR_W-1:0]       sr;
   logic                  hdr_last;
   logic                  word_last;
   logic                  hdr_write;
   logic [ADDR_WIDTH-1:0] hdr_addr;
   logic [DW-1:0]         word;
   logic                  cnt_en;
   logic                  shift_en;
   logic                  hdr_done;
   logic                  word_done;

   spi_sync_edge #(.RESET_VAL(1'b0)) u_sck_sync (
      .clk    (clk),
      ._reset (_reset),
      .din    (sck),
      .rise   (sck_rise),
      .fall   (sck_fall)
   );

   spi_sync_edge #(.RESET_VAL(1'b1)) u_sel_sync (
      .clk    (clk),
      ._reset (_reset),
      .din    (_select),
      .rise   (sel_rise),
      .fall   (sel_fall)
   );

   // mosi only needs to be stable by the time the delayed sck rise is seen.
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         mosi_meta <= 1'b0;
         mosi_s    <= 1'b0;
      end else begin
         mosi_meta <= mosi;
         mosi_s    <= mosi_meta;
      end
   end

   // The bit arriving this cycle completes the header/word together with sr.
   assign hdr_last  = (bit_cnt == CNT_W'(HDR_W - 1));
   assign word_last = (bit_cnt == CNT_W'(DW - 1));
   assign hdr_write = (sr[HDR_W-2] == SPI_MEM_WRITE_FLAG);
   assign hdr_addr  = {sr[ADDR_WIDTH-2:0], mosi_s};
   assign word      = {sr[DW-2:0], mosi_s};

   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         state <= SPI_MEM_STATE_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      state_next = state;
      cnt_en     = 1'b0;
      shift_en   = 1'b0;
      hdr_done   = 1'b0;
      word_done  = 1'b0;
      case (state)
         SPI_MEM_STATE_IDLE: begin
            if (sel_fall) state_next = SPI_MEM_STATE_HEADER;
         end
         SPI_MEM_STATE_HEADER: begin
            if (sck_rise) begin
               cnt_en   = 1'b1;
               shift_en = 1'b1;
               if (hdr_last) begin
                  hdr_done   = 1'b1;
                  state_next = hdr_write ? SPI_MEM_STATE_WRITE : SPI_MEM_STATE_READ;
               end
            end
         end
         SPI_MEM_STATE_WRITE: begin
            if (sck_rise) begin
               cnt_en    = 1'b1;
               shift_en  = 1'b1;
               word_done = word_last;
            end
         end
         SPI_MEM_STATE_READ: begin
            if (sck_rise) begin
               cnt_en    = 1'b1;
               word_done = word_last;
            end
         end
         default: state_next = SPI_MEM_STATE_IDLE;
      endcase
      // Deselect wins over a coincident last bit: the word is dropped.
      if (sel_rise) begin
         state_next = SPI_MEM_STATE_IDLE;
         cnt_en     = 1'b0;
         shift_en   = 1'b0;
         hdr_done   = 1'b0;
         word_done  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         bit_cnt  <= '0;
         sr       <= '0;
         addr     <= '0;
         data_out <= '0;
         rd       <= 1'b0;
         wr       <= 1'b0;
      end else begin
         rd <= 1'b0;
         wr <= 1'b0;

         if (state == SPI_MEM_STATE_IDLE && sel_fall) begin
            bit_cnt <= '0;
            sr      <= '0;
         end else if (cnt_en) begin
            bit_cnt <= (hdr_done || word_done) ? '0 : bit_cnt + CNT_W'(1);
         end

         if (shift_en) sr <= {sr[SR_W-2:0], mosi_s};

         // A write uses the current address; it advances the cycle after wr.
         if (wr) addr <= addr + ADDR_WIDTH'(1);

         if (hdr_done) begin
            addr <= hdr_addr;
`ifdef SPI_MEM_READBACK_EN
            rd   <= ~hdr_write;
`endif
         end

         if (word_done && state == SPI_MEM_STATE_WRITE) begin
            data_out <= word;
            wr       <= 1'b1;
         end

`ifdef SPI_MEM_READBACK_EN
         // Prefetch: the next address is presented together with its rd.
         if (word_done && state == SPI_MEM_STATE_READ) begin
            addr <= addr + ADDR_WIDTH'(1);
            rd   <= 1'b1;
         end
`endif
      end
   end

`ifdef SPI_MEM_READBACK_EN
   logic [READ_LATENCY-1:0] rd_dly;
   logic [DW-1:0]           out_sr;
   logic                    out_en;

   // Falls at a word boundary (bit_cnt == 0) do not shift, so a freshly
   // loaded word keeps its MSB on miso until the master samples it.
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         rd_dly <= '0;
         out_sr <= '0;
         out_en <= 1'b0;
      end else begin
         rd_dly <= READ_LATENCY'({rd_dly, rd});
         if (sel_rise) begin
            out_sr <= '0;
            out_en <= 1'b0;
         end else begin
            if (hdr_done && !hdr_write) out_en <= 1'b1;
            if (rd_dly[READ_LATENCY-1] && state == SPI_MEM_STATE_READ) begin
               out_sr <= data_in;
            end else if (sck_fall && state == SPI_MEM_STATE_READ && bit_cnt != '0) begin
               out_sr <= {out_sr[DW-2:0], 1'b0};
            end
         end
      end
   end

   assign miso    = out_sr[DW-1];
   assign miso_en = out_en & ~sel_rise;
`else
   logic unused_read;
   assign unused_read = ^{data_in, sck_fall, 2'(READ_LATENCY)};
   assign miso        = 1'b0;
   assign miso_en     = 1'b0;
`endif

endmodule
